progress_bar: RTL
=================

PROGRESS_BAR -- requirements
Module: progress_bar

Interface
REQ-001 SHALL have parameters X0 (default 10), Y0 (default 60), BAR_W (default 10) and BAR_H (default 360), giving the bar outline corners in pixels.
REQ-002 SHALL have parameter MAX_SECS (default 180), the full-scale countdown; ZONE_HI (default 120) and ZONE_LO (default 60), the colour thresholds in seconds.
REQ-003 SHALL have parameter ORIENT (default 0): 0 = vertical bar filling bottom-up, 1 = horizontal bar filling left-to-right.
REQ-004 SHALL have parameters BLINK_SECS (default 10) and BLINK_FRAMES (default 16).
REQ-005 SHALL have port CLK, input, 1 bit: the single pixel clock.
REQ-006 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports minutes and seconds, each input, 6 bits: remaining time.
REQ-008 SHALL have ports DrawX and DrawY, each input, 10 bits: current pixel coordinate.
REQ-009 SHALL have port frame_start, input, 1 bit: a one-cycle pulse once per frame during blanking.
REQ-010 SHALL have ports red, green and blue, each output, 4 bits: pixel colour.
REQ-011 SHALL have port bar_active, output, 1 bit: the pixel lies on or inside the outline.

Function
REQ-012 SHALL compute rem = min(minutes*60 + seconds, MAX_SECS) with a 12-bit intermediate, registered every cycle.
REQ-013 SHALL set L = BAR_H-1 (ORIENT=0) or BAR_W-1 (ORIENT=1).
REQ-014 SHALL, on frame_start in IDLE, latch rem and start a restoring divider computing fill_len = floor(rem*L/MAX_SECS), one quotient bit per cycle.
REQ-015 SHALL use divider FSM states IDLE -> DIV (one cycle per numerator bit) -> DONE (one cycle: commit fill_len and rem_frame) -> IDLE.
REQ-016 SHALL ignore frame_start while in DIV or DONE.
REQ-017 SHALL render using only the committed fill_len and rem_frame, so the bar never changes mid-frame.
REQ-018 SHALL increment a frame counter on each frame_start; blink_phase toggles when the counter reaches BLINK_FRAMES-1, and the counter then wraps to 0.
REQ-019 SHALL have 1-cycle pixel latency: outputs for (DrawX, DrawY) are valid the cycle after presentation.
REQ-020 SHALL draw outline pixels (X==X0, X==X0+BAR_W, Y==Y0 or Y==Y0+BAR_H, within the span) as black (0,0,0).
REQ-021 SHALL treat an interior pixel as filled when DrawY >= Y0+BAR_H-fill_len (ORIENT=0) or DrawX <= X0+fill_len (ORIENT=1), excluding the outline.
REQ-022 SHALL colour filled pixels green (0,A,0) if rem_frame >= ZONE_HI, yellow (F,F,5) if rem_frame >= ZONE_LO, otherwise red (A,0,0).
REQ-023 SHALL colour unfilled interior pixels grey (A,A,A); when rem_frame == 0 the whole interior is grey.
REQ-024 SHALL, when 0 < rem_frame <= BLINK_SECS and blink_phase == 1, colour filled pixels grey.
REQ-025 SHALL drive outputs 0 and bar_active 0 outside the outline.

Reset
REQ-026 SHALL, while RESET_N is low, asynchronously force red/green/blue=0, bar_active=0, FSM=IDLE, fill_len=0, rem_frame=0, frame counter=0 and blink_phase=0.
REQ-027 SHALL, when reset is asserted during DIV, discard the partial quotient; the first frame_start after release starts a fresh division.

Structure
REQ-028 SHALL place the divider state enum and the colour constants (BLACK, GREY, GREEN, YELLOW, RED) in shared package progress_pkg.
REQ-029 SHALL implement the divider as sub-module seq_divider (start/busy/done, parametrised widths).

Verification
REQ-030 SHALL verify: defaults, minutes=3 seconds=0, frame_start -> fill_len=359; pixel (15,61) green (0,A,0); (10,200) black.
REQ-031 SHALL verify: minutes=1 seconds=30 -> fill_len=179; (15,241) yellow; (15,240) grey.
REQ-032 SHALL verify: minutes=0 seconds=30 -> fill_len=59; (15,361) red; (15,360) grey.
REQ-033 SHALL verify: minutes=5 seconds=0 -> clamped to 180, full green; minutes=0 seconds=0 -> interior all grey.
REQ-034 SHALL verify: seconds=5 over 32 frames -> filled pixels red for frames 0-15, grey for 16-31; outline stays black.
REQ-035 SHALL verify: RESET_N low during DIV -> outputs 0 that cycle; next frame_start yields the correct fill_len. Also: ORIENT=1, BAR_W=100, rem=90 -> fill_len=49.

Source files
------------

// File: rtl/progress_pkg.sv
// Shared types for the countdown progress bar: divider FSM states and pixel colours.
package progress_pkg;

   typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t BLACK  = 12'h000;
   localparam rgb_t GREY   = 12'hAAA;
   localparam rgb_t GREEN  = 12'h0A0;
   localparam rgb_t YELLOW = 12'hFF5;
   localparam rgb_t RED    = 12'hA00;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; quo is valid while done is high.
module seq_divider
   import progress_pkg::*;
#(
   parameter int NUM_W = 16,
   parameter int DEN_W = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quo
);

   localparam int CW = $clog2(NUM_W + 1);

   div_state_t       state, nxt;
   logic [NUM_W-1:0] q_sh;
   logic [DEN_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [DEN_W:0]   trial;
   logic             ge;

   // q_sh shifts the numerator out at the top while quotient bits enter at the bottom
   assign trial = {acc, q_sh[NUM_W-1]};
   assign ge    = trial >= {1'b0, den};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         q_sh  <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (start) begin
               q_sh <= num;
               acc  <= '0;
               cnt  <= '0;
            end
            DIV: begin
               acc  <= ge ? DEN_W'(trial - {1'b0, den}) : trial[DEN_W-1:0];
               q_sh <= {q_sh[NUM_W-2:0], ge};
               cnt  <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = DIV;
         DIV:     if (cnt == CW'(NUM_W - 1)) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign busy = state != IDLE;
   assign done = state == DONE;
   assign quo  = q_sh;

endmodule

// File: rtl/progress_bar.sv
// Countdown progress bar overlay: fill length is recomputed once per frame, pixels drawn with 1-cycle latency.
module progress_bar
   import progress_pkg::*;
#(
   parameter int X0           = 10,
   parameter int Y0           = 60,
   parameter int BAR_W        = 10,
   parameter int BAR_H        = 360,
   parameter int MAX_SECS     = 180,
   parameter int ZONE_HI      = 120,
   parameter int ZONE_LO      = 60,
   parameter int ORIENT       = 0,
   parameter int BLINK_SECS   = 10,
   parameter int BLINK_FRAMES = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       frame_start,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       bar_active
);

   localparam int L      = (ORIENT == 0) ? BAR_H - 1 : BAR_W - 1;
   localparam int REM_W  = $clog2(MAX_SECS + 1);
   localparam int NUM_W  = $clog2(MAX_SECS * L + 1);
   localparam int FILL_W = $clog2(L + 1);
   localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [11:0]       tot;
   logic [REM_W-1:0]  rem_r, rem_lat, rem_frame;
   logic [FILL_W-1:0] fill_len;
   logic [FC_W-1:0]   frame_cnt;
   logic              blink_phase;
   logic              start, busy, done;
   logic [NUM_W-1:0]  quo;

   assign tot   = 12'(minutes) * 12'd60 + 12'(seconds);
   assign start = frame_start & ~busy;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rem_r       <= '0;
         rem_lat     <= '0;
         rem_frame   <= '0;
         fill_len    <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         rem_r <= (tot > 12'(MAX_SECS)) ? REM_W'(MAX_SECS) : REM_W'(tot);
         if (start) rem_lat <= rem_r;
         // commit both together so a frame never mixes old and new values
         if (done) begin
            fill_len  <= FILL_W'(quo);
            rem_frame <= rem_lat;
         end
         if (frame_start) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   seq_divider #(
      .NUM_W (NUM_W),
      .DEN_W (REM_W)
   ) u_div (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .start   (start),
      .num     (NUM_W'(int'(rem_r) * L)),
      .den     (REM_W'(MAX_SECS)),
      .busy    (busy),
      .done    (done),
      .quo     (quo)
   );

   int   px, py, fl, rf;
   logic in_span, on_edge, filled;
   rgb_t pix;

   assign px = int'(DrawX);
   assign py = int'(DrawY);
   assign fl = int'(fill_len);
   assign rf = int'(rem_frame);

   always_comb begin
      pix     = BLACK;
      in_span = (px >= X0) && (px <= X0 + BAR_W) && (py >= Y0) && (py <= Y0 + BAR_H);
      on_edge = (px == X0) || (px == X0 + BAR_W) || (py == Y0) || (py == Y0 + BAR_H);
      filled  = (rf != 0) && ((ORIENT == 0) ? (py >= Y0 + BAR_H - fl) : (px <= X0 + fl));
      if (in_span && !on_edge) begin
         if (!filled || (blink_phase && rf <= BLINK_SECS)) pix = GREY;
         else if (rf >= ZONE_HI)                           pix = GREEN;
         else if (rf >= ZONE_LO)                           pix = YELLOW;
         else                                              pix = RED;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         red        <= '0;
         green      <= '0;
         blue       <= '0;
         bar_active <= 1'b0;
      end else begin
         red        <= pix.r;
         green      <= pix.g;
         blue       <= pix.b;
         bar_active <= in_span;
      end
   end

endmodule
